pipeline_event_monitor: RTL and testbench

Parametrised, synthesizable performance/halt monitor for the RISC_V pipeline. It attaches to the same debug taps the processor exports: PC_MEM, PCSrc, pipeline_stall, forwardA and forwardB. It counts cycles, stalls, taken branches and forwarding events, and detects program completion when PC_MEM stays at one value for a run of cycles. Benches and on-chip debug read the results through a select/readout port, replacing fixed-time $finish runs.

---
 rtl/pipeline_event_monitor_if.sv | 28 ++
 rtl/pipeline_event_monitor.sv | 109 ++++++++++
 tb/tb_pipeline_event_monitor.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_event_monitor_if.sv
// Debug-tap and readout bundle between the RISC-V pipeline taps and the event monitor.
// The master side drives the taps and the readout select; the monitor is the slave.
interface pipeline_event_monitor_if #(
    parameter int CNT_WIDTH = 32,
    parameter int PC_WIDTH  = 32
);
    logic                 en;
    logic                 clr;
    logic [PC_WIDTH-1:0]  pc_mem;
    logic                 pcsrc;
    logic                 pipeline_stall;
    logic [1:0]           forward_a;
    logic [1:0]           forward_b;
    logic [2:0]           cnt_sel;
    logic [CNT_WIDTH-1:0] cnt_value;
    logic                 halted;
    logic                 overflow;

    modport master (
        output en, clr, pc_mem, pcsrc, pipeline_stall, forward_a, forward_b, cnt_sel,
        input  cnt_value, halted, overflow
    );

    modport slave (
        input  en, clr, pc_mem, pcsrc, pipeline_stall, forward_a, forward_b, cnt_sel,
        output cnt_value, halted, overflow
    );
endinterface

// File: rtl/pipeline_event_monitor.sv
// Pipeline performance/halt monitor: saturating event counters, stuck-PC halt
// detection and a registered-source readout mux.
module pipeline_event_monitor #(
    parameter int CNT_WIDTH   = 32,
    parameter int PC_WIDTH    = 32,
    parameter int HALT_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    pipeline_event_monitor_if.slave  mon
);
    localparam int NUM_CNT = 5;

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t                              state;
    logic [NUM_CNT-1:0][CNT_WIDTH-1:0]   cnt;
    logic [NUM_CNT-1:0][CNT_WIDTH-1:0]   cnt_nxt;
    logic [NUM_CNT-1:0]                  ev;
    logic [NUM_CNT-1:0]                  sat;
    logic [7:0]                          stuck;
    logic [PC_WIDTH-1:0]                 prev_pc;
    logic [PC_WIDTH-1:0]                 halt_pc;
    logic                                prev_valid;
    logic                                halted_q;
    logic                                overflow_q;
    logic                                same_pc;
    logic                                stuck_inc;
    logic                                halt_hit;
    logic [CNT_WIDTH-1:0]                rd_value;

    // Counter order matches readout selects 0..4: cyc, stl, br, fa, fb.
    assign ev = {mon.forward_b != 2'b00, mon.forward_a != 2'b00,
                 mon.pcsrc, mon.pipeline_stall, 1'b1};

    genvar i;
    generate
        for (i = 0; i < NUM_CNT; i++) begin : g_cnt
            assign sat[i]     = ev[i] && (cnt[i] == {CNT_WIDTH{1'b1}});
            assign cnt_nxt[i] = (ev[i] && !sat[i]) ? cnt[i] + CNT_WIDTH'(1) : cnt[i];
        end
    endgenerate

    // A stalled sample with an unchanged PC neither extends nor breaks the run.
    assign same_pc   = prev_valid && (mon.pc_mem == prev_pc);
    assign stuck_inc = same_pc && !mon.pipeline_stall;
    assign halt_hit  = stuck_inc && (stuck == 8'(HALT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            stuck      <= '0;
            prev_pc    <= '0;
            prev_valid <= 1'b0;
            halt_pc    <= '0;
            halted_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else if (mon.clr) begin
            state      <= IDLE;
            cnt        <= '0;
            stuck      <= '0;
            prev_pc    <= '0;
            prev_valid <= 1'b0;
            halt_pc    <= '0;
            halted_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (mon.en) state <= RUN;
                RUN: begin
                    cnt        <= cnt_nxt;
                    prev_pc    <= mon.pc_mem;
                    prev_valid <= mon.en;
                    if (|sat) overflow_q <= 1'b1;
                    if (stuck_inc)    stuck <= stuck + 8'd1;
                    else if (!same_pc) stuck <= '0;
                    // Halt wins over a simultaneous en drop; the run is over either way.
                    if (halt_hit) begin
                        state    <= HALTED;
                        halted_q <= 1'b1;
                        halt_pc  <= mon.pc_mem;
                    end else if (!mon.en) begin
                        state <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_value = '0;
        case (mon.cnt_sel)
            3'd0:    rd_value = cnt[0];
            3'd1:    rd_value = cnt[1];
            3'd2:    rd_value = cnt[2];
            3'd3:    rd_value = cnt[3];
            3'd4:    rd_value = cnt[4];
            3'd5:    rd_value = CNT_WIDTH'(stuck);
            3'd6:    rd_value = CNT_WIDTH'(halt_pc);
            default: rd_value = '0;
        endcase
    end

    assign mon.cnt_value = rd_value;
    assign mon.halted    = halted_q;
    assign mon.overflow  = overflow_q;
endmodule

// File: tb/tb_pipeline_event_monitor.sv
// Directed bench for pipeline_event_monitor: a 32-bit-counter instance for the
// main scenarios and a 4-bit-counter instance for saturation.
module tb_pipeline_event_monitor;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #10 clk = ~clk;

    pipeline_event_monitor_if #(.CNT_WIDTH(32), .PC_WIDTH(32)) m();
    pipeline_event_monitor_if #(.CNT_WIDTH(4),  .PC_WIDTH(32)) s();

    pipeline_event_monitor #(.CNT_WIDTH(32), .PC_WIDTH(32), .HALT_CYCLES(8)) u_dut (
        .clk(clk), .reset(reset), .mon(m.slave));
    pipeline_event_monitor #(.CNT_WIDTH(4), .PC_WIDTH(32), .HALT_CYCLES(8)) u_sat (
        .clk(clk), .reset(reset), .mon(s.slave));

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [2:0] sel, output logic [31:0] v);
        m.cnt_sel = sel; #1; v = m.cnt_value;
    endtask

    task automatic rds(input logic [2:0] sel, output logic [3:0] v);
        s.cnt_sel = sel; #1; v = s.cnt_value;
    endtask

    task automatic drv(input logic [31:0] pc, input logic st, input logic br,
                       input logic [1:0] fa, input logic [1:0] fb);
        m.pc_mem = pc; m.pipeline_stall = st; m.pcsrc = br; m.forward_a = fa; m.forward_b = fb;
    endtask

    task automatic clear_m();
        m.clr = 1'b1; tick(); m.clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b0; m.en = 1'b0; s.en = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (5) tick();
        for (int k = 0; k < 8; k++) begin
            rd(3'(k), v); total++;
            if (v !== 32'd0) begin bad++; $display("FAIL reset_sel%0d got=%0h exp=0", k, v); end
        end
        total++; if (m.halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", m.halted); end
        total++; if (m.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", m.overflow); end
        m.en = 1'b1; tick();
        drv(32'h10, 0, 1, 2'b01, 2'b00); tick();
        drv(32'h14, 0, 0, 2'b00, 2'b00); tick();
        rd(3'd0, v); total++;
        if (v !== 32'd2) begin bad++; $display("FAIL pre_clr_cyc got=%0d exp=2", v); end
        clear_m();
        for (int k = 0; k < 8; k++) begin
            rd(3'(k), v); total++;
            if (v !== 32'd0) begin bad++; $display("FAIL clr_sel%0d got=%0h exp=0", k, v); end
        end
        tick();
        rd(3'd0, v); total++;
        if (v !== 32'd0) begin bad++; $display("FAIL clr_idle_cyc got=%0d exp=0", v); end
        tick();
        rd(3'd0, v); total++;
        if (v !== 32'd1) begin bad++; $display("FAIL clr_resume_cyc got=%0d exp=1", v); end
        m.en = 1'b0; tick();
    endtask

    task automatic test_count();
        logic [31:0] v;
        logic [9:0] st_v = 10'b0000100010;
        logic [9:0] br_v = 10'b0010001001;
        logic [9:0] fa_v = 10'b0100010101;
        logic [9:0] fb_v = 10'b0001000000;
        clear_m();
        m.en = 1'b1; tick();
        for (int e = 0; e < 10; e++) begin
            drv(32'h100 + 32'(4 * e), st_v[e], br_v[e], fa_v[e] ? 2'b01 : 2'b00, fb_v[e] ? 2'b10 : 2'b00);
            tick();
        end
        rd(3'd0, v); total++; if (v !== 32'd10) begin bad++; $display("FAIL count_cyc got=%0d exp=10", v); end
        rd(3'd1, v); total++; if (v !== 32'd2)  begin bad++; $display("FAIL count_stl got=%0d exp=2", v); end
        rd(3'd2, v); total++; if (v !== 32'd3)  begin bad++; $display("FAIL count_br got=%0d exp=3", v); end
        rd(3'd3, v); total++; if (v !== 32'd4)  begin bad++; $display("FAIL count_fa got=%0d exp=4", v); end
        rd(3'd4, v); total++; if (v !== 32'd1)  begin bad++; $display("FAIL count_fb got=%0d exp=1", v); end
        rd(3'd5, v); total++; if (v !== 32'd0)  begin bad++; $display("FAIL count_stuck got=%0d exp=0", v); end
        total++; if (m.halted !== 1'b0) begin bad++; $display("FAIL count_halted got=%b exp=0", m.halted); end
        drv(32'h0, 0, 0, 2'b00, 2'b00);
        m.en = 1'b0; tick();
    endtask

    task automatic test_halt();
        logic [31:0] v;
        clear_m();
        m.en = 1'b1; tick();
        for (int k = 0; k < 5; k++) begin drv(32'h30 + 32'(4 * k), 0, 0, 2'b00, 2'b00); tick(); end
        for (int r = 1; r <= 8; r++) begin
            drv(32'h40, 0, 0, 2'b00, 2'b00); tick();
            if (r == 7) begin
                total++; if (m.halted !== 1'b0) begin bad++; $display("FAIL halt_early got=%b exp=0", m.halted); end
                rd(3'd5, v); total++; if (v !== 32'd7) begin bad++; $display("FAIL halt_stuck7 got=%0d exp=7", v); end
            end
        end
        total++; if (m.halted !== 1'b1) begin bad++; $display("FAIL halt_set got=%b exp=1", m.halted); end
        rd(3'd6, v); total++; if (v !== 32'h40) begin bad++; $display("FAIL halt_pc got=%0h exp=40", v); end
        rd(3'd0, v); total++; if (v !== 32'd13) begin bad++; $display("FAIL halt_cyc got=%0d exp=13", v); end
        for (int k = 0; k < 20; k++) begin
            drv(32'h80 + 32'(4 * k), 1, 1, 2'b11, 2'b11); m.en = k[0]; tick();
        end
        rd(3'd0, v); total++; if (v !== 32'd13) begin bad++; $display("FAIL frozen_cyc got=%0d exp=13", v); end
        rd(3'd2, v); total++; if (v !== 32'd0)  begin bad++; $display("FAIL frozen_br got=%0d exp=0", v); end
        rd(3'd5, v); total++; if (v !== 32'd8)  begin bad++; $display("FAIL frozen_stuck got=%0d exp=8", v); end
        total++; if (m.halted !== 1'b1) begin bad++; $display("FAIL frozen_halted got=%b exp=1", m.halted); end
        drv(32'h0, 0, 0, 2'b00, 2'b00); m.en = 1'b0;
    endtask

    task automatic test_stall_stuck();
        logic [31:0] v;
        clear_m();
        m.en = 1'b1; tick();
        for (int k = 0; k < 5; k++) begin drv(32'h30 + 32'(4 * k), 0, 0, 2'b00, 2'b00); tick(); end
        for (int p = 1; p <= 11; p++) begin
            drv(32'h40, (p == 2 || p == 5 || p == 8), 0, 2'b00, 2'b00); tick();
            if (p == 1 || p == 2) begin
                rd(3'd5, v); total++;
                if (v !== 32'd1) begin bad++; $display("FAIL stall_hold_p%0d got=%0d exp=1", p, v); end
            end
            if (p == 10) begin
                total++; if (m.halted !== 1'b0) begin bad++; $display("FAIL stall_early got=%b exp=0", m.halted); end
            end
        end
        total++; if (m.halted !== 1'b1) begin bad++; $display("FAIL stall_halt got=%b exp=1", m.halted); end
        rd(3'd1, v); total++; if (v !== 32'd3) begin bad++; $display("FAIL stall_stl got=%0d exp=3", v); end
        drv(32'h0, 0, 0, 2'b00, 2'b00);
        clear_m();
        tick();
        for (int k = 0; k < 4; k++) begin drv(32'h40, 0, 0, 2'b00, 2'b00); tick(); end
        rd(3'd5, v); total++; if (v !== 32'd3) begin bad++; $display("FAIL run_stuck got=%0d exp=3", v); end
        drv(32'h44, 0, 0, 2'b00, 2'b00); tick();
        rd(3'd5, v); total++; if (v !== 32'd0) begin bad++; $display("FAIL pc_change_stuck got=%0d exp=0", v); end
        m.en = 1'b0; tick();
    endtask

    task automatic test_saturation();
        logic [3:0] v;
        s.clr = 1'b1; tick(); s.clr = 1'b0;
        s.en = 1'b1; tick();
        for (int e = 1; e <= 20; e++) begin
            s.pc_mem = 32'h200 + 32'(4 * e); s.pcsrc = 1'b1; tick();
            if (e == 15) begin
                rds(3'd0, v); total++; if (v !== 4'd15) begin bad++; $display("FAIL sat15_cyc got=%0d exp=15", v); end
                total++; if (s.overflow !== 1'b0) begin bad++; $display("FAIL sat15_ovf got=%b exp=0", s.overflow); end
            end
            if (e == 16) begin
                total++; if (s.overflow !== 1'b1) begin bad++; $display("FAIL sat16_ovf got=%b exp=1", s.overflow); end
            end
        end
        rds(3'd0, v); total++; if (v !== 4'd15) begin bad++; $display("FAIL sat_cyc got=%0d exp=15", v); end
        rds(3'd2, v); total++; if (v !== 4'd15) begin bad++; $display("FAIL sat_br got=%0d exp=15", v); end
        s.en = 1'b0; s.pcsrc = 1'b0;
        repeat (3) tick();
        total++; if (s.overflow !== 1'b1) begin bad++; $display("FAIL sat_sticky got=%b exp=1", s.overflow); end
        s.clr = 1'b1; tick(); s.clr = 1'b0;
        total++; if (s.overflow !== 1'b0) begin bad++; $display("FAIL sat_clr_ovf got=%b exp=0", s.overflow); end
        rds(3'd0, v); total++; if (v !== 4'd0) begin bad++; $display("FAIL sat_clr_cyc got=%0d exp=0", v); end
    endtask

    task automatic test_pause_reset();
        logic [31:0] v;
        clear_m();
        m.en = 1'b1; tick();
        for (int k = 0; k < 4; k++) begin drv(32'h40, 0, 0, 2'b00, 2'b00); tick(); end
        m.en = 1'b0;
        repeat (5) tick();
        rd(3'd0, v); total++; if (v !== 32'd5) begin bad++; $display("FAIL pause_cyc got=%0d exp=5", v); end
        rd(3'd5, v); total++; if (v !== 32'd4) begin bad++; $display("FAIL pause_stuck got=%0d exp=4", v); end
        m.en = 1'b1; tick();
        tick();
        rd(3'd0, v); total++; if (v !== 32'd6) begin bad++; $display("FAIL resume_cyc got=%0d exp=6", v); end
        rd(3'd5, v); total++; if (v !== 32'd0) begin bad++; $display("FAIL resume_stuck got=%0d exp=0", v); end
        repeat (8) tick();
        total++; if (m.halted !== 1'b1) begin bad++; $display("FAIL resume_halt got=%b exp=1", m.halted); end
        @(posedge clk); #7;
        reset = 1'b0; #1;
        total++; if (m.halted !== 1'b0) begin bad++; $display("FAIL async_halted got=%b exp=0", m.halted); end
        rd(3'd0, v); total++; if (v !== 32'd0) begin bad++; $display("FAIL async_cyc got=%0d exp=0", v); end
        rd(3'd6, v); total++; if (v !== 32'd0) begin bad++; $display("FAIL async_halt_pc got=%0h exp=0", v); end
        m.en = 1'b0; tick(); reset = 1'b1; tick();
    endtask

    initial begin
        reset = 1'b0;
        m.en = 1'b0; m.clr = 1'b0; m.cnt_sel = 3'd0;
        drv(32'h0, 0, 0, 2'b00, 2'b00);
        s.en = 1'b0; s.clr = 1'b0; s.cnt_sel = 3'd0; s.pc_mem = 32'h0;
        s.pcsrc = 1'b0; s.pipeline_stall = 1'b0; s.forward_a = 2'b00; s.forward_b = 2'b00;
        test_reset();
        test_count();
        test_halt();
        test_stall_stuck();
        test_saturation();
        test_pause_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
